// File: rtl/cache_perf_pkg.sv
// Shared constants, types and helpers for the multi-channel cache performance monitor.
package cache_perf_pkg;

  localparam logic [3:0] ST_RDHIT  = 4'd9;
  localparam logic [3:0] ST_WRHIT  = 4'd6;
  localparam logic [3:0] ST_RDMISS = 4'd2;
  localparam logic [3:0] ST_WRMISS = 4'd7;

  // Index of each counter within a channel's counter bank
  localparam int C_HIT = 0;
  localparam int C_TOT = 1;
  localparam int C_RDM = 2;
  localparam int C_WRM = 3;
  localparam int NCNT  = 4;

  typedef enum logic [2:0] {EV_NONE, EV_RDHIT, EV_WRHIT, EV_RDMISS, EV_WRMISS} ev_t;

  typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT} ratio_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic ev_t decode_ev(input logic [3:0] code);
    case (code)
      ST_RDHIT:  return EV_RDHIT;
      ST_WRHIT:  return EV_WRHIT;
      ST_RDMISS: return EV_RDMISS;
      ST_WRMISS: return EV_WRMISS;
      default:   return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/perf_ratio_div.sv
// Sequential restoring divider, one quotient bit per cycle, start/busy/done handshake.
// A start while busy abandons the current division and reloads the operands.
module perf_ratio_div
  import cache_perf_pkg::*;
#(
  parameter int DVW = 20,
  parameter int DSW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DVW-1:0] dividend,
  input  logic [DSW-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [DVW-1:0] quotient
);

  localparam int IW = cnt_width(DVW);

  logic [DSW-1:0] rem;
  logic [DSW-1:0] dsr;
  logic [IW-1:0]  iter;
  logic [DSW:0]   rem_sh;
  logic [DSW:0]   diff;
  logic           take_bit;

  // Dividend bits shift out of the quotient register into the remainder
  assign rem_sh   = {rem, quotient[DVW-1]};
  assign diff     = rem_sh - {1'b0, dsr};
  assign take_bit = ~diff[DSW];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      dsr      <= '0;
      iter     <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        rem      <= '0;
        dsr      <= divisor;
        quotient <= dividend;
        iter     <= IW'(DVW - 1);
      end else if (busy) begin
        rem      <= take_bit ? diff[DSW-1:0] : rem_sh[DSW-1:0];
        quotient <= {quotient[DVW-2:0], take_bit};
        if (iter == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          iter <= iter - IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cache_perf_counter.sv
// Multi-channel cache hit/miss monitor with live counters, snapshots and sticky overflow.
// Define CACHE_PERF_RATIO_EN to add the per-channel Q0.8 hit-ratio divider and ports.
module cache_perf_counter
  import cache_perf_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 12,
  parameter int WIN_W    = 16,
  parameter int WIN_LEN  = 0,
  parameter int EDGE_CNT = 1,
  parameter int SAT      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*NCH-1:0]   cs,
  input  logic               en,
  input  logic               clr,
  input  logic               snap_req,
  output logic               snap_valid,
  output logic [CNT_W*NCH-1:0] hitc,
  output logic [CNT_W*NCH-1:0] totalc,
  output logic [CNT_W*NCH-1:0] rdmissc,
  output logic [CNT_W*NCH-1:0] wrmissc,
  output logic [NCH-1:0]     ovf
`ifdef CACHE_PERF_RATIO_EN
  ,
  output logic [8*NCH-1:0]   ratio,
  output logic               ratio_valid
`endif
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WIN_LEN == 0) ? 0 : WIN_LEN - 1);

  logic [WIN_W-1:0] timer;
  logic             trigger;
  logic             take;

  assign trigger = snap_req || ((WIN_LEN != 0) && en && (timer == WIN_LAST));
  assign take    = trigger && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= take;
      if (clr || trigger)
        timer <= '0;
      else if (en && (WIN_LEN != 0))
        timer <= timer + WIN_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [3:0]       cs_k;
    logic [3:0]       prev_cs;
    ev_t              ev;
    logic             fire;
    logic [NCNT-1:0]  inc;
    logic [NCNT-1:0]  wrap;
    logic [CNT_W-1:0] live [NCNT];
    logic [CNT_W-1:0] nxt  [NCNT];
    logic [CNT_W-1:0] snap [NCNT];
    logic             ovf_r;

    assign cs_k = cs[4*g +: 4];

    // Next live values include this cycle's event so a snapshot taken now sees it
    always_comb begin
      ev   = decode_ev(cs_k);
      fire = en && (ev != EV_NONE) && ((EDGE_CNT == 0) || (cs_k != prev_cs));
      inc  = '0;
      if (fire) begin
        inc[C_TOT] = 1'b1;
        case (ev)
          EV_RDHIT, EV_WRHIT: inc[C_HIT] = 1'b1;
          EV_RDMISS:          inc[C_RDM] = 1'b1;
          EV_WRMISS:          inc[C_WRM] = 1'b1;
          default:            ;
        endcase
      end
      for (int c = 0; c < NCNT; c++) begin
        wrap[c] = inc[c] && (live[c] == '1);
        if (!inc[c] || (wrap[c] && (SAT != 0)))
          nxt[c] = live[c];
        else
          nxt[c] = live[c] + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_cs <= '0;
        ovf_r   <= 1'b0;
        for (int c = 0; c < NCNT; c++) begin
          live[c] <= '0;
          snap[c] <= '0;
        end
      end else begin
        prev_cs <= cs_k;
        if (clr) begin
          ovf_r <= 1'b0;
          for (int c = 0; c < NCNT; c++) live[c] <= '0;
        end else begin
          ovf_r <= ovf_r | (|wrap);
          for (int c = 0; c < NCNT; c++) begin
            if (trigger) begin
              snap[c] <= nxt[c];
              live[c] <= '0;
            end else begin
              live[c] <= nxt[c];
            end
          end
        end
      end
    end

    assign hitc   [CNT_W*g +: CNT_W] = snap[C_HIT];
    assign totalc [CNT_W*g +: CNT_W] = snap[C_TOT];
    assign rdmissc[CNT_W*g +: CNT_W] = snap[C_RDM];
    assign wrmissc[CNT_W*g +: CNT_W] = snap[C_WRM];
    assign ovf[g] = ovf_r;
  end

`ifdef CACHE_PERF_RATIO_EN
  localparam int DVW  = CNT_W + 8;
  localparam int CH_W = cnt_width(NCH);

  ratio_state_t     rstate;
  logic [CH_W-1:0]  rch;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DVW-1:0]   div_q;
  logic [CNT_W-1:0] sel_hit;
  logic [CNT_W-1:0] sel_tot;
  logic [7:0]       rres;

  assign sel_hit   = hitc  [CNT_W*int'(rch) +: CNT_W];
  assign sel_tot   = totalc[CNT_W*int'(rch) +: CNT_W];
  assign div_start = (rstate == R_START);

  // hitc==totalc yields 256, which Q0.8 cannot hold, hence the clamp
  always_comb begin
    rres = div_q[7:0];
    if (sel_tot == '0)
      rres = 8'h00;
    else if (|div_q[DVW-1:8])
      rres = 8'hFF;
  end

  perf_ratio_div #(.DVW(DVW), .DSW(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({sel_hit, 8'h00}),
    .divisor  (sel_tot),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate      <= R_IDLE;
      rch         <= '0;
      ratio       <= '0;
      ratio_valid <= 1'b0;
    end else if (take) begin
      rstate      <= R_START;
      rch         <= '0;
      ratio_valid <= 1'b0;
    end else begin
      case (rstate)
        R_START: rstate <= R_WAIT;
        R_WAIT: begin
          if (div_done) begin
            ratio[8*int'(rch) +: 8] <= rres;
            if (rch == CH_W'(NCH - 1)) begin
              ratio_valid <= 1'b1;
              rstate      <= R_IDLE;
            end else begin
              rch    <= rch + CH_W'(1);
              rstate <= R_START;
            end
          end else if (!div_busy) begin
            rstate <= R_START;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cache_perf_counter.sv
// Directed bench for cache_perf_counter: several parameterisations share one stimulus stream.
module tb_cache_perf_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cs;
  logic       en;
  logic       clr;
  logic       snap_req;

  int checks   = 0;
  int failures = 0;

  logic        a_sv, e_sv, s_sv, w_sv, win_sv;
  logic [23:0] a_hitc, a_totc, a_rdm, a_wrm;
  logic [23:0] e_hitc, e_totc, e_rdm, e_wrm;
  logic [7:0]  s_hitc, s_totc, s_rdm, s_wrm;
  logic [7:0]  w_hitc, w_totc, w_rdm, w_wrm;
  logic [23:0] win_hitc, win_totc, win_rdm, win_wrm;
  logic [1:0]  a_ovf, e_ovf, s_ovf, w_ovf, win_ovf;
`ifdef CACHE_PERF_RATIO_EN
  logic [15:0] a_ratio, e_ratio, s_ratio, w_ratio, win_ratio;
  logic        a_rv, e_rv, s_rv, w_rv, win_rv;
`endif

  always #5 clk = ~clk;

  cache_perf_counter #(.NCH(2), .CNT_W(12), .EDGE_CNT(1), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .cs(cs), .en(en), .clr(clr), .snap_req(snap_req),
    .snap_valid(a_sv), .hitc(a_hitc), .totalc(a_totc), .rdmissc(a_rdm), .wrmissc(a_wrm),
    .ovf(a_ovf)
`ifdef CACHE_PERF_RATIO_EN
    , .ratio(a_ratio), .ratio_valid(a_rv)
`endif
  );

  cache_perf_counter #(.NCH(2), .CNT_W(12), .EDGE_CNT(0), .SAT(1)) u_e (
    .clk(clk), .rst(rst), .cs(cs), .en(en), .clr(clr), .snap_req(snap_req),
    .snap_valid(e_sv), .hitc(e_hitc), .totalc(e_totc), .rdmissc(e_rdm), .wrmissc(e_wrm),
    .ovf(e_ovf)
`ifdef CACHE_PERF_RATIO_EN
    , .ratio(e_ratio), .ratio_valid(e_rv)
`endif
  );

  cache_perf_counter #(.NCH(2), .CNT_W(4), .EDGE_CNT(1), .SAT(1)) u_s (
    .clk(clk), .rst(rst), .cs(cs), .en(en), .clr(clr), .snap_req(snap_req),
    .snap_valid(s_sv), .hitc(s_hitc), .totalc(s_totc), .rdmissc(s_rdm), .wrmissc(s_wrm),
    .ovf(s_ovf)
`ifdef CACHE_PERF_RATIO_EN
    , .ratio(s_ratio), .ratio_valid(s_rv)
`endif
  );

  cache_perf_counter #(.NCH(2), .CNT_W(4), .EDGE_CNT(1), .SAT(0)) u_w (
    .clk(clk), .rst(rst), .cs(cs), .en(en), .clr(clr), .snap_req(snap_req),
    .snap_valid(w_sv), .hitc(w_hitc), .totalc(w_totc), .rdmissc(w_rdm), .wrmissc(w_wrm),
    .ovf(w_ovf)
`ifdef CACHE_PERF_RATIO_EN
    , .ratio(w_ratio), .ratio_valid(w_rv)
`endif
  );

  // Auto-window instance never sees manual snapshot requests
  cache_perf_counter #(.NCH(2), .CNT_W(12), .WIN_LEN(8), .EDGE_CNT(1), .SAT(1)) u_win (
    .clk(clk), .rst(rst), .cs(cs), .en(en), .clr(clr), .snap_req(1'b0),
    .snap_valid(win_sv), .hitc(win_hitc), .totalc(win_totc), .rdmissc(win_rdm), .wrmissc(win_wrm),
    .ovf(win_ovf)
`ifdef CACHE_PERF_RATIO_EN
    , .ratio(win_ratio), .ratio_valid(win_rv)
`endif
  );

  typedef struct {
    logic [7:0]  cs;
    logic [23:0] hit;
    logic [23:0] tot;
    logic [23:0] rdm;
    logic [23:0] wrm;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [23:0] pk(input int c1, input int c0);
    return {12'(c1), 12'(c0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cs_v, input logic snap_v,
                               input logic clr_v, input logic en_v);
    cs       = cs_v;
    snap_req = snap_v;
    clr      = clr_v;
    en       = en_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h69, pk(1, 1), pk(1, 1), pk(0, 0), pk(0, 0)};
    vecs[1] = '{8'h72, pk(0, 0), pk(1, 1), pk(0, 1), pk(1, 0)};
    vecs[2] = '{8'h27, pk(0, 0), pk(1, 1), pk(1, 0), pk(0, 1)};
    vecs[3] = '{8'h10, pk(0, 0), pk(0, 0), pk(0, 0), pk(0, 0)};
    vecs[4] = '{8'hF3, pk(0, 0), pk(0, 0), pk(0, 0), pk(0, 0)};
    vecs[5] = '{8'h95, pk(1, 0), pk(1, 0), pk(0, 0), pk(0, 0)};
    vecs[6] = '{8'h8A, pk(0, 0), pk(0, 0), pk(0, 0), pk(0, 0)};
    vecs[7] = '{8'h06, pk(0, 1), pk(0, 1), pk(0, 0), pk(0, 0)};

    rst = 1'b1; cs = 8'h99; en = 1'b1; clr = 1'b0; snap_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_hitc",   32'(a_hitc), 0);
    checkOutput("rst_totalc", 32'(a_totc), 0);
    checkOutput("rst_rdmiss", 32'(a_rdm),  0);
    checkOutput("rst_wrmiss", 32'(a_wrm),  0);
    checkOutput("rst_ovf",    32'(a_ovf),  0);
    checkOutput("rst_snapv",  32'(a_sv),   0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(8'h09, 1'b0, 1'b0, 1'b1);
    checkOutput("snapv_before", 32'(a_sv), 0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("snapv_pulse",   32'(a_sv), 1);
    checkOutput("edge_hitc0",    32'(a_hitc[11:0]), 1);
    checkOutput("edge_totalc0",  32'(a_totc[11:0]), 1);
    checkOutput("level_hitc0",   32'(e_hitc[11:0]), 5);
    checkOutput("level_totalc0", 32'(e_totc[11:0]), 5);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("snapv_after", 32'(a_sv), 0);

    applyStimulus(8'h90, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h60, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h20, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h70, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("seq_hitc1",    32'(a_hitc[23:12]), 2);
    checkOutput("seq_totalc1",  32'(a_totc[23:12]), 4);
    checkOutput("seq_rdmissc1", 32'(a_rdm[23:12]),  1);
    checkOutput("seq_wrmissc1", 32'(a_wrm[23:12]),  1);
    checkOutput("seq_hitc0",    32'(a_hitc[11:0]),  0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].cs, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_snapv", v),   32'(a_sv),   1);
      checkOutput($sformatf("vec%0d_hitc", v),    32'(a_hitc), 32'(vecs[v].hit));
      checkOutput($sformatf("vec%0d_totalc", v),  32'(a_totc), 32'(vecs[v].tot));
      checkOutput($sformatf("vec%0d_rdmissc", v), 32'(a_rdm),  32'(vecs[v].rdm));
      checkOutput($sformatf("vec%0d_wrmissc", v), 32'(a_wrm),  32'(vecs[v].wrm));
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    end

    applyStimulus(8'h09, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h99, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("en0_snapv",  32'(a_sv),   1);
    checkOutput("en0_totalc", 32'(a_totc), 0);

    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h09, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_hitc0",   32'(s_hitc[3:0]),  15);
    checkOutput("sat_totalc0", 32'(s_totc[3:0]),  15);
    checkOutput("sat_ovf",     32'(s_ovf),        1);
    checkOutput("wrap_hitc0",  32'(w_hitc[3:0]),  4);
    checkOutput("wrap_ovf",    32'(w_ovf),        1);
    checkOutput("wide_hitc0",  32'(a_hitc[11:0]), 20);
    checkOutput("wide_ovf",    32'(a_ovf),        0);

    applyStimulus(8'h09, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
    checkOutput("clrsnap_snapv", 32'(a_sv),          0);
    checkOutput("clrsnap_hitc0", 32'(a_hitc[11:0]), 20);
    checkOutput("clrsnap_ovf",   32'(s_ovf),         0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("clrsnap_live_snapv", 32'(a_sv),   1);
    checkOutput("clrsnap_live_tot",   32'(a_totc), 0);

    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      applyStimulus((i % 2 == 1) ? 8'h09 : 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("win_snapv_c%0d", i), 32'(win_sv), (i % 8 == 0) ? 1 : 0);
      if (i % 8 == 0)
        checkOutput($sformatf("win_totalc_c%0d", i), 32'(win_totc[11:0]), 4);
    end

    begin
      int pulses = 0;
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
        applyStimulus((i % 2 == 0) ? 8'h09 : 8'h00, 1'b0, 1'b0, 1'b0);
        if (win_sv === 1'b1) pulses++;
      end
      checkOutput("win_en0_pulses", 32'(pulses), 0);
    end

`ifdef CACHE_PERF_RATIO_EN
    begin
      int n;
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'h99, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h09, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h09, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h02, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
      checkOutput("ratio_valid_drop", 32'(a_rv), 0);
      checkOutput("ratio_hitc0",      32'(a_hitc[11:0]), 3);
      n = 0;
      while (a_rv !== 1'b1 && n < 300) begin
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        n++;
      end
      checkOutput("ratio_valid", 32'(a_rv), 1);
      checkOutput("ratio0_3of4", 32'(a_ratio[7:0]),  192);
      checkOutput("ratio1_full", 32'(a_ratio[15:8]), 255);

      applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
      n = 0;
      while (a_rv !== 1'b1 && n < 300) begin
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        n++;
      end
      checkOutput("ratio_valid_zero", 32'(a_rv), 1);
      checkOutput("ratio_zero_tot",   32'(a_ratio), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
